// File: rtl/battousai_mem_seq.sv
// battousai_mem_seq: multicycle load/store sequencer for a 64-bit data memory.
// Sub-doubleword stores read-modify-write; sd writes directly; loads extend.
// Ports: clk, reset (async, active-low), start/is_store/funct3/addr/store_data
//   request (sampled in IDLE); mem_rdata in; mem_addr/mem_we/mem_wdata out;
//   load_data, busy, done status; misalign only with MISALIGN_TRAP_EN defined.
// Option: `define MISALIGN_TRAP_EN to trap misaligned halfword/word/dword access.
module battousai_mem_seq #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [63:0] load_data,
  output logic        busy,
  output logic        done
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        st_q, st_d;
  logic [2:0]  f3_q, f3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] sd_q, sd_d;
  logic [63:0] rd_buf_q, rd_buf_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [63:0] load_data_q, load_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Access size code: 0=byte 1=half 2=word 3=dword.
  // Stores with funct3 4..7 are treated as sd.
  function automatic logic [1:0] size_of(
    input logic st, input logic [2:0] f3);
    return (st && f3[2]) ? 2'd3 : f3[1:0];
  endfunction

  function automatic logic [63:0] merge(
    input logic [63:0] rb, input logic [63:0] sd,
    input logic [1:0] sz);
    logic [63:0] r;
    unique case (sz)
      2'd0:    r = {rb[63:8],  sd[7:0]};
      2'd1:    r = {rb[63:16], sd[15:0]};
      2'd2:    r = {rb[63:32], sd[31:0]};
      default: r = sd;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ext(
    input logic [63:0] rb, input logic [2:0] f3);
    logic [63:0] r;
    logic        sx;
    sx = ~f3[2];
    unique case (f3[1:0])
      2'd0:    r = {{56{sx & rb[7]}},  rb[7:0]};
      2'd1:    r = {{48{sx & rb[15]}}, rb[15:0]};
      2'd2:    r = {{32{sx & rb[31]}}, rb[31:0]};
      default: r = rb;
    endcase
    return r;
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic mis_in;
  always_comb begin
    mis_in = 1'b0;
    unique case (size_of(is_store, funct3))
      2'd1:    mis_in = addr[0];
      2'd2:    mis_in = |addr[1:0];
      2'd3:    mis_in = |addr[2:0];
      default: mis_in = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    sd_d        = sd_q;
    rd_buf_d    = rd_buf_q;
    load_data_d = load_data_q;
`ifdef MISALIGN_TRAP_EN
    mis_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          st_d   = is_store;
          f3_d   = funct3;
          addr_d = addr;
          sd_d   = store_data;
          cnt_d  = 3'd0;
`ifdef MISALIGN_TRAP_EN
          if (mis_in) begin
            state_d = DONE;
            mis_d   = 1'b1;
          end else
`endif
          if (is_store &&
              size_of(is_store, funct3) == 2'd3)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ: begin
        if (cnt_q == LAST) begin
          cnt_d    = 3'd0;
          rd_buf_d = mem_rdata;
          if (st_q) begin
            state_d = WRITE;
          end else begin
            state_d     = DONE;
            load_data_d = ext(rd_buf_d, f3_q);
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they
    // line up with the state they belong to.
    mem_addr_d  = (state_d == READ || state_d == WRITE)
                  ? addr_d : 64'd0;
    mem_we_d    = (state_d == WRITE);
    mem_wdata_d = (state_d == WRITE)
                  ? merge(rd_buf_d, sd_d, size_of(st_d, f3_d))
                  : 64'd0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      st_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 64'd0;
      sd_q        <= 64'd0;
      rd_buf_q    <= 64'd0;
      mem_addr_q  <= 64'd0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 64'd0;
      load_data_q <= 64'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      sd_q        <= sd_d;
      rd_buf_q    <= rd_buf_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign load_data = load_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign  = mis_q;
`endif

endmodule

// File: tb/tb_battousai_mem_seq.sv
// tb_battousai_mem_seq: directed + random checks of battousai_mem_seq
// at MEM_LAT=1 (instance 0) and MEM_LAT=3 (instance 1).
module tb_battousai_mem_seq;

  logic        clk;
  logic        reset_n;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic        start     [2];
  logic [63:0] mem_rdata [2];
  logic [63:0] mem_addr  [2];
  logic        mem_we    [2];
  logic [63:0] mem_wdata [2];
  logic [63:0] load_data [2];
  logic        busy      [2];
  logic        done      [2];
`ifdef MISALIGN_TRAP_EN
  logic        misalign  [2];
`endif
  logic [63:0] mem_word  [2];
  logic [63:0] ld_model  [2];

  int vecs = 0;
  int miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    int rcnt = 0;
    // Memory returns the stored word only on the L-th
    // consecutive read cycle; earlier cycles see garbage.
    always_ff @(posedge clk)
      if (mem_addr[g] != 64'd0 && !mem_we[g]) rcnt <= rcnt + 1;
      else rcnt <= 0;
    assign mem_rdata[g] = (rcnt == L - 1) ? mem_word[g] : ~mem_word[g];

    battousai_mem_seq #(.MEM_LAT(L)) u_dut (
      .clk        (clk),
      .reset      (reset_n),
      .start      (start[g]),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .mem_rdata  (mem_rdata[g]),
      .mem_addr   (mem_addr[g]),
      .mem_we     (mem_we[g]),
      .mem_wdata  (mem_wdata[g]),
      .load_data  (load_data[g]),
      .busy       (busy[g]),
      .done       (done[g])
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign   (misalign[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Number of bytes touched by the access.
  function automatic int bytes_of(input logic st, input logic [2:0] f3);
    if (st && f3 >= 3) return 8;
    return 1 << f3[1:0];
  endfunction

  task automatic do_op(input int i, input logic st, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] sd,
                       input logic [63:0] old, input bit poke,
                       output logic [63:0] wd_o, output logic [63:0] ld_o);
    int nb, lat_e, rd_e, we_e, cyc, wes, rds;
    bit got, emis, sgn;
    logic [63:0] mask, ewd, eld;
    nb   = bytes_of(st, f3);
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    ewd  = (old & ~mask) | (sd & mask);
    sgn  = !f3[2] && nb < 8 && old[8 * nb - 1];
    eld  = (old & mask) | (sgn ? ~mask : 64'd0);
    emis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    emis = (a % 64'(nb)) != 64'd0;
`endif
    if (emis) begin
      lat_e = 1; rd_e = 0; we_e = 0;
    end else if (st && nb == 8) begin
      lat_e = 2; rd_e = 0; we_e = 1;
    end else if (st) begin
      lat_e = lat_of(i) + 2; rd_e = lat_of(i); we_e = 1;
    end else begin
      lat_e = lat_of(i) + 1; rd_e = lat_of(i); we_e = 0;
    end
    if (!st && !emis) ld_model[i] = eld;
    mem_word[i] = old;
    is_store = st; funct3 = f3; addr = a; store_data = sd;
    wd_o = 64'd0;
    start[i] = 1'b1;
    got = 0; cyc = 0; wes = 0; rds = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start[i] = 1'b0;
      if (mem_we[i]) begin
        wes++;
        wd_o = mem_wdata[i];
        chk("wdata", mem_wdata[i], ewd);
        chk("waddr", mem_addr[i], a);
      end else begin
        chk("idle_wdata", mem_wdata[i], 64'd0);
        if (mem_addr[i] != 64'd0) begin
          rds++;
          chk("raddr", mem_addr[i], a);
        end
      end
      chk("busy", 64'(busy[i]), 64'd1);
      if (done[i]) got = 1;
`ifdef MISALIGN_TRAP_EN
      chk("misalign", 64'(misalign[i]), 64'(got && emis));
`endif
      // Extra starts while busy and in the DONE cycle must be dropped.
      if (poke && (cyc == 2 || got)) begin
        start[i] = 1'b1;
        is_store = ~st;
        addr = a ^ 64'h40;
      end
    end
    ld_o = load_data[i];
    chk("latency", 64'(cyc), 64'(lat_e));
    chk("we_count", 64'(wes), 64'(we_e));
    chk("read_cycles", 64'(rds), 64'(rd_e));
    chk("load_data", load_data[i], ld_model[i]);
    @(negedge clk);
    start[i] = 1'b0;
    chk("idle_busy", 64'(busy[i]), 64'd0);
    chk("idle_done", 64'(done[i]), 64'd0);
    chk("idle_addr", mem_addr[i], 64'd0);
    chk("idle_we", 64'(mem_we[i]), 64'd0);
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_addr"}, mem_addr[i], 64'd0);
    chk({tag, "_we"}, 64'(mem_we[i]), 64'd0);
    chk({tag, "_wdata"}, mem_wdata[i], 64'd0);
    chk({tag, "_ld"}, load_data[i], 64'd0);
    chk({tag, "_busy"}, 64'(busy[i]), 64'd0);
    chk({tag, "_done"}, 64'(done[i]), 64'd0);
  endtask

  initial begin
    logic [63:0] wd, ld, a, sd, old;
    logic [2:0]  f3;
    logic        st;
    bit          seen_we;
    reset_n = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    is_store = 1'b0; funct3 = 3'd0; addr = 64'd0; store_data = 64'd0;
    mem_word[0] = 64'd0; mem_word[1] = 64'd0;
    ld_model[0] = 64'd0; ld_model[1] = 64'd0;
    repeat (2) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    reset_n = 1'b1;
    @(negedge clk);

    do_op(0, 1, 3'd0, 64'h1000, 64'hAA, 64'h1122334455667788, 0, wd, ld);
    chk("tp_sb", wd, 64'h11223344556677AA);
    do_op(0, 1, 3'd3, 64'h2008, 64'hDEADBEEFCAFEF00D, 64'h5555, 0, wd, ld);
    chk("tp_sd", wd, 64'hDEADBEEFCAFEF00D);
    do_op(0, 0, 3'd1, 64'h3000, 64'd0, 64'h00000000FFFF8001, 0, wd, ld);
    chk("tp_lh", ld, 64'hFFFFFFFFFFFF8001);
    do_op(0, 0, 3'd5, 64'h3000, 64'd0, 64'h00000000FFFF8001, 1, wd, ld);
    chk("tp_lhu", ld, 64'h0000000000008001);
    do_op(0, 0, 3'd2, 64'h3000, 64'd0, 64'h00000000FFFF8001, 0, wd, ld);
    chk("tp_lw", ld, 64'hFFFFFFFFFFFF8001);
    do_op(1, 1, 3'd2, 64'h4000, 64'h12345678, '1, 1, wd, ld);
    chk("tp_sw", wd, 64'hFFFFFFFF12345678);
    do_op(1, 0, 3'd0, 64'h4001, 64'd0, 64'h80, 0, wd, ld);
    chk("tp_lb", ld, 64'hFFFFFFFFFFFFFF80);

    for (int n = 0; n < 60; n++) begin
      st  = 1'($urandom);
      f3  = 3'($urandom);
      a   = {$urandom, $urandom} | 64'h1000;
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
      sd  = {$urandom, $urandom};
      old = {$urandom, $urandom};
      do_op(n % 2, st, f3, a, sd, old, ($urandom_range(0, 3) == 0), wd, ld);
    end

    // Reset in the middle of an sb read on the MEM_LAT=3 instance.
    mem_word[1] = 64'h0123456789ABCDEF;
    is_store = 1'b1; funct3 = 3'd0; addr = 64'h5000; store_data = 64'h77;
    start[1] = 1'b1;
    seen_we = 0;
    repeat (2) begin
      @(negedge clk);
      start[1] = 1'b0;
      if (mem_we[1]) seen_we = 1;
    end
    chk("pre_rst_busy", 64'(busy[1]), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_zero(1, "midrst");
    ld_model[0] = 64'd0; ld_model[1] = 64'd0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (mem_we[1] || done[1] || busy[1]) seen_we = 1;
    end
    chk("rst_no_activity", 64'(seen_we), 64'd0);
    do_op(1, 1, 3'd0, 64'h5000, 64'h77, 64'h0123456789ABCDEF, 0, wd, ld);
    chk("post_rst_sb", wd, 64'h0123456789ABCD77);
    do_op(1, 0, 3'd6, 64'h6000, 64'd0, 64'hFFFFFFFF_80000000, 0, wd, ld);
    chk("post_rst_lwu", ld, 64'h0000000080000000);

`ifdef MISALIGN_TRAP_EN
    do_op(0, 1, 3'd2, 64'h1002, 64'h1, 64'h0, 0, wd, ld);
    chk("mis_sw_nowrite", wd, 64'd0);
    do_op(1, 0, 3'd3, 64'h1004, 64'h0, 64'h1234, 0, wd, ld);
    chk("mis_ld_hold", ld, 64'h0000000080000000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
